// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; result = {HI, LO}.
// Optional DIV_EARLY_EXIT_EN: finish at once when |a| < |b|.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    END
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   rem, rem_n;
  logic [WIDTH-1:0]   quo, quo_n;
  logic [WIDTH-1:0]   dvs, dvs_n;
  logic               neg_q, neg_q_n;
  logic               neg_r, neg_r_n;
  logic [2*WIDTH-1:0] result_n;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   q_step, r_step;

  // Partial remainder stays below the divisor, so a WIDTH+1 bit
  // difference carries a trustworthy sign bit.
  always_comb begin
    mag_a   = (signed_div && a[WIDTH-1]) ? -a : a;
    mag_b   = (signed_div && b[WIDTH-1]) ? -b : b;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    q_step  = {quo[WIDTH-2:0], ~diff[WIDTH]};
    r_step  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    quo_n    = quo;
    dvs_n    = dvs;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    result_n = result;
    unique case (state)
      IDLE: begin
        if (start && !annul) begin
          if (b == '0) begin
            result_n = {a, {WIDTH{1'b1}}};
            state_n  = END;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (mag_a < mag_b) begin
            result_n = {a, {WIDTH{1'b0}}};
            state_n  = END;
          end
`endif
          else begin
            neg_q_n = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_n = signed_div & a[WIDTH-1];
            quo_n   = mag_a;
            dvs_n   = mag_b;
            rem_n   = '0;
            cnt_n   = '0;
            state_n = ON;
          end
        end
      end
      ON: begin
        if (annul) begin
          state_n = IDLE;
        end else begin
          rem_n = r_step;
          quo_n = q_step;
          cnt_n = cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state_n  = END;
            result_n = {neg_r ? -r_step : r_step,
                        neg_q ? -q_step : q_step};
          end
        end
      end
      END: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rem    <= rem_n;
      quo    <= quo_n;
      dvs    <= dvs_n;
      neg_q  <= neg_q_n;
      neg_r  <= neg_r_n;
      result <= result_n;
    end
  end

  // An annulled completion is never reported.
  assign ready = (state == END) && !annul;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, monitor pops on ready.
// Expected latency honours DIV_EARLY_EXIT_EN for the |a| < |b| vector.
`timescale 1ns/1ps
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        ready, busy;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .annul(annul), .a(a), .b(b), .result(result),
    .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] res;
    int          lat;
    time         t0;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_ready: got ready=1 expected no ready, result %h",
                 result);
      end else begin
        exp_t e;
        int   lat;
        e   = sbq.pop_front();
        lat = int'((($time - 5) - e.t0) / 10) + 1;
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_latency"}, 64'(lat), 64'(e.lat));
      end
    end
  end

  task automatic do_start(input logic sd, input logic [31:0] av,
                          input logic [31:0] bv, output time t0);
    @(posedge clk);
    #1;
    signed_div = sd;
    a          = av;
    b          = bv;
    start      = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    start = 1'b0;
  endtask

  task automatic do_div(input string name, input logic sd,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] res, input int lat);
    exp_t e;
    time  t0;
    do_start(sd, av, bv, t0);
    e.name = name;
    e.res  = res;
    e.lat  = lat;
    e.t0   = t0;
    sbq.push_back(e);
    @(negedge clk);
    chk({name, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no ready expected ready within 100 cycles",
               name);
      sbq.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  localparam int FULL = 33;
`ifdef DIV_EARLY_EXIT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = FULL;
`endif

  initial begin
    time t0;
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    a          = '0;
    b          = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Start while busy must be ignored.
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, FULL);
    repeat (3) @(posedge clk);
    #1;
    a     = 32'd1;
    b     = 32'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("divu_100_7");

    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD}, FULL);
    wait_idle("div_m7_2");
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
           {32'd1, 32'hFFFF_FFFD}, FULL);
    wait_idle("div_7_m2");
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           {32'd0, 32'h8000_0000}, FULL);
    wait_idle("div_ovf");
    do_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000,
           {32'h7FFF_FFFF, 32'd1}, FULL);
    wait_idle("divu_big");
    do_div("div_zero_s", 1'b1, 32'hFFFF_FFF9, 32'd0,
           {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1);
    wait_idle("div_zero_s");
    do_div("divu_zero", 1'b0, 32'h1234_5678, 32'd0,
           {32'h1234_5678, 32'hFFFF_FFFF}, 1);
    wait_idle("divu_zero");

    // Annul mid-division: no ready, result kept.
    do_start(1'b0, 32'd100, 32'd7, t0);
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    @(negedge clk);
    chk("annul_busy", 64'(busy), 64'd0);
    chk("annul_result", result, {32'h1234_5678, 32'hFFFF_FFFF});
    repeat (40) @(posedge clk);

    // Annul in IDLE drops a simultaneous start.
    @(posedge clk);
    #1;
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    annul = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    @(negedge clk);
    chk("annul_idle_busy", 64'(busy), 64'd0);
    repeat (40) @(posedge clk);

    // Reset mid-division.
    do_start(1'b0, 32'd50, 32'd5, t0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_result", result, 64'd0);
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (40) @(posedge clk);

    do_div("divu_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, FULL);
    wait_idle("divu_50_5");
    do_div("divu_3_9", 1'b0, 32'd3, 32'd9, {32'd3, 32'd0}, SMALL_LAT);
    wait_idle("divu_3_9");
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
           {32'd0, 32'hFFFF_FFFF}, FULL);
    wait_idle("divu_max_1");

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring integer divider for MIPS DIV/DIVU.
- Produces quotient (LO) and remainder (HI) and stalls the pipeline while busy.
- Sits in the EX stage beside the combinational ALU. The ALU covers single-cycle add/sub/logic/shift; this unit covers the iterative inverse of multiplication.
- Results are written to the HI/LO registers when `ready` pulses.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must be at least clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- annul  input  1  cancel the in-flight division (exception or flush).
- a  input  WIDTH  dividend; sampled with start.
- b  input  WIDTH  divisor; sampled with start.
- result  output  2*WIDTH  {remainder, quotient}, i.e. {HI, LO}; registered.
- ready  output  1  one-cycle pulse; `result` is valid and new this cycle.
- busy  output  1  high in ON and END; the pipeline stalls on it.

Behaviour:
- Reset: synchronous on rst=1. State=IDLE; result=0; ready=0; busy=0; counter=0; internal registers cleared. Reset wins over every other input, including mid-division.
- States: IDLE, ON, END.
- IDLE, start=1, b≠0 (edge E0):
  - Latch the sign flags.
  - Load |a| and |b| when signed_div=1, raw values otherwise.
  - Clear the partial remainder; counter=0; go to ON.
- IDLE, start=1, b=0 (edge E0):
  - Go directly to END with result={a, all-ones}, raw a regardless of signed_div.
- ON: each edge performs one iteration.
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor in a WIDTH+1-bit difference. If non-negative, keep it and set quotient bit 1; else restore and set quotient bit 0.
  - Counter increments. The iteration with counter=WIDTH-1 is the last; that edge goes to END.
- ON result write (on the final edge E32):
  - Signed: quotient negated when a[31]^b[31]; remainder negated when a[31].
  - 0x80000000 / 0xFFFFFFFF signed: quotient=0x80000000, remainder=0. Natural wrap, no trap.
- END: ready=1 for exactly one cycle, then IDLE on the next edge. result holds its value until the next completion.
- Latency: ready is high in the cycle after E32, i.e. WIDTH+1 cycles after the start-sampling edge. Divide-by-zero case: the cycle after E0.
- start while busy: ignored, no queueing.
- start in the END cycle: ignored; the requester re-asserts it.
- annul:
  - In ON or END: next edge goes to IDLE; ready stays/becomes 0; result unchanged.
  - In IDLE: annul overrides start; the request is dropped.
- No overflow flag; MIPS DIV never traps.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - At E0, if b≠0 and the loaded |a| < |b| (unsigned compare of the loaded magnitudes), go directly to END with result={a, 0}.
  - Raw a is kept, so sign is preserved; ready occurs the cycle after E0.
- Undefined: all b≠0 divisions take the full WIDTH+1-cycle latency. Results are identical in both builds.

Test Plan:
- DIVU a=100, b=7 -> ready exactly 33 cycles after the start edge; result={32'd2, 32'd14}; busy high for 33 cycles.
- DIV a=-7 (0xFFFFFFF9), b=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- DIVU a=0x12345678, b=0 -> ready the cycle after E0; result={0x12345678, 0xFFFFFFFF}.
- Abort cases:
  - Start 100/7, assert annul at cycle 10 -> IDLE next edge, no ready, result unchanged.
  - Start 50/5, rst=1 at cycle 5 -> all outputs 0.
  - New 50/5 after the abort -> {0, 10} at normal latency.
- DIVU a=3, b=9 -> result={3, 0}. Ready after 33 cycles without DIV_EARLY_EXIT_EN; after 1 cycle with it.
